// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller.
//   - irq_state_e : controller FSM states (IDLE, REQ, SERVICE)
//   - *_DEF       : default parameter values for irq_controller
//   - prio_t / prio_encode : fixed-priority encoder, lowest set bit wins
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int          N_SRC_DEF      = 8;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0040;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'd4;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so source 0 always has the highest priority.
  function automatic prio_t prio_encode(input logic [15:0] req);
    prio_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source input conditioning: two-flop synchroniser followed by a delay
// flop, producing a one-cycle pulse on each synchronised rising edge.
// Ports:
//   clk    in  system clock, rising edge
//   Rst    in  asynchronous active-low reset
//   src_i  in  raw asynchronous interrupt line
//   rise_o out one-cycle pulse when the synchronised line goes 0 -> 1
module irq_edge_sync (
  input  logic clk,
  input  logic Rst,
  input  logic src_i,
  output logic rise_o
);

  logic sync0_q;
  logic sync1_q;
  logic dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value from before the edge; blocking here would collapse
  // the synchroniser into a single stage.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync0_q <= src_i;
      sync1_q <= sync0_q;
      dly_q   <= sync1_q;
    end
  end

  assign rise_o = sync1_q & ~dly_q;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller feeding the multi-cycle CPU core.
// Raw source lines are synchronised and edge-detected into a pending register,
// qualified by a software mask, and the lowest-index eligible source is
// presented to the core with its handler address. Ack/EOI pulses from the core
// walk the controller through REQ and SERVICE; there is no nesting.
// Ports:
//   clk        in  system clock, rising edge
//   Rst        in  asynchronous active-low reset
//   Src        in  [N_SRC] raw interrupt lines, rising edge requests service
//   Mask_W     in  strobe: load Mask_Data into the mask
//   Mask_Data  in  [N_SRC] new mask, 1 = source enabled
//   INT_Ack    in  core entered the handler
//   INT_EOI    in  core left the handler
//   EX_irq     out registered interrupt request
//   INT_Vector out [32] registered handler address, valid while EX_irq = 1
//   INT_ID     out [4] source being requested or serviced
//   Pending    out [N_SRC] pending register
//   Busy       out 1 while in REQ or SERVICE
module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_SRC      = N_SRC_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [N_SRC-1:0] Src,
  input  logic             Mask_W,
  input  logic [N_SRC-1:0] Mask_Data,
  input  logic             INT_Ack,
  input  logic             INT_EOI,
  output logic             EX_irq,
  output logic [31:0]      INT_Vector,
  output logic [3:0]       INT_ID,
  output logic [N_SRC-1:0] Pending,
  output logic             Busy
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [3:0]       int_id_q, int_id_d;
  logic             ex_irq_q, ex_irq_d;
  logic [31:0]      vector_q, vector_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] pend_clr;
  logic [15:0]      elig_wide;
  prio_t            winner;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk    (clk),
      .Rst    (Rst),
      .src_i  (Src[g]),
      .rise_o (rise[g])
    );
  end

  assign eligible = pending_q & mask_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    elig_wide = '0;
    elig_wide[N_SRC-1:0] = eligible;
    winner    = prio_encode(elig_wide);

    id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (int_id_q == 4'(i)) id_onehot[i] = 1'b1;
    end

    state_d  = state_q;
    int_id_d = int_id_q;
    ex_irq_d = ex_irq_q;
    vector_d = vector_q;
    pend_clr = '0;

    unique case (state_q)
      IDLE: begin
        if (winner.valid) begin
          int_id_d = winner.idx;
          ex_irq_d = 1'b1;
          vector_d = VEC_BASE + 32'(winner.idx) * VEC_STRIDE;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so it beats a same-cycle mask clear.
        if (INT_Ack) begin
          pend_clr = id_onehot;
          ex_irq_d = 1'b0;
          state_d  = SERVICE;
        end else if ((eligible & id_onehot) == '0) begin
          // Source masked off while waiting: withdraw, keep it pending.
          ex_irq_d = 1'b0;
          state_d  = IDLE;
        end
      end
      SERVICE: begin
        ex_irq_d = 1'b0;
        if (INT_EOI) state_d = IDLE;
      end
      default: begin
        ex_irq_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // A fresh edge in the Ack cycle must not be lost, so set beats clear.
    pending_d = (pending_q & ~pend_clr) | rise;
    mask_d    = Mask_W ? Mask_Data : mask_q;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      int_id_q  <= '0;
      ex_irq_q  <= 1'b0;
      vector_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_id_q  <= int_id_d;
      ex_irq_q  <= ex_irq_d;
      vector_q  <= vector_d;
    end
  end

  assign EX_irq     = ex_irq_q;
  assign INT_Vector = vector_q;
  assign INT_ID     = int_id_q;
  assign Pending    = pending_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a random
// phase, all compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam int          N  = 8;
  localparam logic [31:0] VB = 32'h0000_0040;
  localparam logic [31:0] VS = 32'd4;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic         clk;
  logic         Rst;
  logic [N-1:0] Src;
  logic         Mask_W;
  logic [N-1:0] Mask_Data;
  logic         INT_Ack;
  logic         INT_EOI;
  logic         EX_irq;
  logic [31:0]  INT_Vector;
  logic [3:0]   INT_ID;
  logic [N-1:0] Pending;
  logic         Busy;

  irq_controller #(
    .N_SRC      (N),
    .VEC_BASE   (VB),
    .VEC_STRIDE (VS)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .Src        (Src),
    .Mask_W     (Mask_W),
    .Mask_Data  (Mask_Data),
    .INT_Ack    (INT_Ack),
    .INT_EOI    (INT_EOI),
    .EX_irq     (EX_irq),
    .INT_Vector (INT_Vector),
    .INT_ID     (INT_ID),
    .Pending    (Pending),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: Src samples taken at each edge; a 0->1 step seen two
  // edges back becomes pending now. Controller state kept as plain ints.
  logic [N-1:0] hist [4];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  int           m_mode;
  int           m_id;
  logic         m_ex;
  logic [31:0]  m_vec;

  task automatic model_reset();
    for (int j = 0; j < 4; j++) hist[j] = '0;
    m_pend = '0;
    m_mask = '0;
    m_mode = M_IDLE;
    m_id   = 0;
    m_ex   = 1'b0;
    m_vec  = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] rise;
    logic [N-1:0] elig;
    int           w;
    if (!Rst) begin
      model_reset();
      return;
    end
    for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = Src;
    rise = hist[2] & ~hist[3];
    elig = m_pend & m_mask;
    if (m_mode == M_IDLE) begin
      if (elig != 0) begin
        w = 0;
        while (!elig[w]) w++;
        m_id   = w;
        m_ex   = 1'b1;
        m_vec  = VB + 32'(w) * VS;
        m_mode = M_REQ;
      end
    end else if (m_mode == M_REQ) begin
      if (INT_Ack) begin
        m_pend[m_id] = 1'b0;
        m_ex   = 1'b0;
        m_mode = M_SVC;
      end else if (!elig[m_id]) begin
        m_ex   = 1'b0;
        m_mode = M_IDLE;
      end
    end else begin
      if (INT_EOI) m_mode = M_IDLE;
    end
    m_pend = m_pend | rise;
    if (Mask_W) m_mask = Mask_Data;
  endtask

  task automatic compare_model();
    check("m_ex",   32'(EX_irq),     32'(m_ex));
    check("m_id",   32'(INT_ID),     32'(m_id));
    check("m_vec",  INT_Vector,      m_vec);
    check("m_pend", 32'(Pending),    32'(m_pend));
    check("m_busy", 32'(Busy),       32'(m_mode != M_IDLE));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    Mask_W = 1'b1; Mask_Data = m;
    cycle();
    Mask_W = 1'b0;
  endtask

  task automatic do_ack();
    INT_Ack = 1'b1;
    cycle();
    INT_Ack = 1'b0;
  endtask

  task automatic do_eoi();
    INT_EOI = 1'b1;
    cycle();
    INT_EOI = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; Src = '0; Mask_W = 1'b0; Mask_Data = '0;
    INT_Ack = 1'b0; INT_EOI = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    cycle();
    check("rst_ex", 32'(EX_irq), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);

    // Reset asynchronously while a request is outstanding.
    write_mask(8'h01);
    Src[0] = 1'b1;
    repeat (4) cycle();
    check("t1_pre_ex", 32'(EX_irq), 32'd1);
    #2 Rst = 1'b0; Src = '0;
    #1;
    check("t1_ex",   32'(EX_irq),  32'd0);
    check("t1_pend", 32'(Pending), 32'd0);
    check("t1_busy", 32'(Busy),    32'd0);
    check("t1_vec",  INT_Vector,   32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    Rst = 1'b1;
    cycle();

    // Single source, latency and handshake.
    write_mask(8'h08);
    Src[3] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check("t2_lat", 32'(EX_irq), 32'(c == 4));
    end
    check("t2_id",  32'(INT_ID), 32'd3);
    check("t2_vec", INT_Vector,  32'h4C);
    Src[3] = 1'b0;
    do_ack();
    check("t2_pend3", 32'(Pending[3]), 32'd0);
    check("t2_ex",    32'(EX_irq),     32'd0);
    check("t2_busy",  32'(Busy),       32'd1);
    do_eoi();
    check("t2_idle",  32'(Busy),       32'd0);

    // Two sources together: priority, then the loser.
    write_mask(8'hFF);
    Src = 8'h24;
    repeat (4) cycle();
    check("t3_id",  32'(INT_ID), 32'd2);
    check("t3_vec", INT_Vector,  32'h48);
    Src = '0;
    do_ack();
    do_eoi();
    cycle();
    check("t3_ex2",  32'(EX_irq), 32'd1);
    check("t3_id2",  32'(INT_ID), 32'd5);
    check("t3_vec2", INT_Vector,  32'h54);
    do_ack();
    do_eoi();

    // Masked source stays pending until enabled.
    write_mask(8'h00);
    Src[1] = 1'b1;
    repeat (4) cycle();
    check("t4_pend", 32'(Pending), 32'h02);
    check("t4_ex",   32'(EX_irq),  32'd0);
    Src[1] = 1'b0;
    write_mask(8'h02);
    cycle();
    check("t4_ex1", 32'(EX_irq), 32'd1);
    check("t4_id",  32'(INT_ID), 32'd1);
    do_ack();
    do_eoi();

    // Withdrawal by mask clear, then mask clear racing Ack.
    write_mask(8'h10);
    Src[4] = 1'b1;
    repeat (4) cycle();
    check("t5_ex", 32'(EX_irq), 32'd1);
    Src[4] = 1'b0;
    write_mask(8'h00);
    cycle();
    check("t5_wd_ex",   32'(EX_irq),     32'd0);
    check("t5_wd_pend", 32'(Pending[4]), 32'd1);
    check("t5_wd_busy", 32'(Busy),       32'd0);
    write_mask(8'h10);
    cycle();
    check("t5_re_ex", 32'(EX_irq), 32'd1);
    Mask_W = 1'b1; Mask_Data = 8'h00; INT_Ack = 1'b1;
    cycle();
    Mask_W = 1'b0; INT_Ack = 1'b0;
    check("t5_ack_busy", 32'(Busy),       32'd1);
    check("t5_ack_pend", 32'(Pending[4]), 32'd0);
    do_eoi();

    // New edge lands in the Ack cycle: set beats clear.
    write_mask(8'h40);
    Src[6] = 1'b1;
    repeat (4) cycle();
    check("t6_ex", 32'(EX_irq), 32'd1);
    Src[6] = 1'b0;
    cycle();
    Src[6] = 1'b1;
    cycle();
    cycle();
    do_ack();
    check("t6_pend6", 32'(Pending[6]), 32'd1);
    check("t6_busy",  32'(Busy),       32'd1);
    do_eoi();
    cycle();
    check("t6_ex2", 32'(EX_irq), 32'd1);
    check("t6_id2", 32'(INT_ID), 32'd6);
    Src[6] = 1'b0;
    do_ack();
    do_eoi();

    // Random traffic, including Ack/EOI outside their states.
    for (int r = 0; r < 1500; r++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) Src[b] = ~Src[b];
      end
      Mask_W    = ($urandom_range(15) == 0);
      Mask_Data = N'($urandom);
      INT_Ack   = ($urandom_range(2) == 0);
      INT_EOI   = ($urandom_range(3) == 0);
      cycle();
    end
    Src = '0; Mask_W = 1'b0; INT_Ack = 1'b0; INT_EOI = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
